// File: rtl/boss_ctrl_pkg.sv
// Shared encodings and default timing for the boss attack-pattern scheduler.
package boss_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INTRO    = 4'd1,
    ST_FAN      = 4'd2,
    ST_FAN_WAIT = 4'd3,
    ST_BIG      = 4'd4,
    ST_BIG_WAIT = 4'd5,
    ST_COOL     = 4'd6,
    ST_FREEZE   = 4'd7,
    ST_DEAD     = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    PH_INACTIVE = 2'd0,
    PH_NORMAL   = 2'd1,
    PH_ENRAGE   = 2'd2,
    PH_DEAD     = 2'd3
  } phase_t;

  localparam int TIMER_W = 8;

  localparam int         DEF_INTRO_TICKS  = 32;
  localparam int         DEF_COOL_TICKS   = 16;
  localparam int         DEF_FAN_VOLLEYS  = 3;
  localparam int         DEF_FREEZE_TICKS = 24;
  localparam int         DEF_WAIT_TIMEOUT = 4;
  localparam logic [7:0] DEF_ENRAGE_HP    = 8'd64;

endpackage

// File: rtl/boss_pattern_ctrl_tick_timer.sv
// Loadable saturating down-counter with zero flag; shared by every timed
// state of the boss scheduler.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/boss_pattern_ctrl.sv
// Boss attack-pattern scheduler: sequences intro, fan volleys, big bullet,
// cooldown, hit-freeze and enrage from boss HP and bullet busy flags.
module boss_pattern_ctrl
  import boss_ctrl_pkg::*;
#(
  parameter int         INTRO_TICKS  = DEF_INTRO_TICKS,
  parameter int         COOL_TICKS   = DEF_COOL_TICKS,
  parameter int         FAN_VOLLEYS  = DEF_FAN_VOLLEYS,
  parameter int         FREEZE_TICKS = DEF_FREEZE_TICKS,
  parameter int         WAIT_TIMEOUT = DEF_WAIT_TIMEOUT,
  parameter logic [7:0] ENRAGE_HP    = DEF_ENRAGE_HP
) (
  input  logic       clk22,
  input  logic       rst,
  input  logic       gamestart,
  input  logic       boss,
  input  logic [7:0] boss_hp,
  input  logic       fan_busy,
  input  logic       big_busy,
  input  logic       shot,
  output logic       fire_fan,
  output logic       fire_big,
  output logic [1:0] phase,
  output logic [2:0] volley_cnt,
  output logic [3:0] state
);

  localparam logic [TIMER_W-1:0] INTRO_LD    = TIMER_W'(INTRO_TICKS - 1);
  localparam logic [TIMER_W-1:0] COOL_LD     = TIMER_W'(COOL_TICKS - 1);
  localparam logic [TIMER_W-1:0] COOL_ENR_LD = TIMER_W'(COOL_TICKS / 2 - 1);
  localparam logic [TIMER_W-1:0] FREEZE_LD   = TIMER_W'(FREEZE_TICKS - 1);
  localparam logic [TIMER_W-1:0] WAIT_LD     = TIMER_W'(WAIT_TIMEOUT - 1);
  localparam logic [2:0]         VOLLEY_NORM = 3'(FAN_VOLLEYS);
  localparam logic [2:0]         VOLLEY_MAX  = 3'(FAN_VOLLEYS + 1);

  state_t             state_q, state_n;
  phase_t             phase_q, phase_n;
  logic [2:0]         volley_q, volley_n, target;
  logic               seen_q, seen_n;
  logic               fire_fan_n, fire_big_n;
  logic               kill, enrage_now, shootable;
  logic               tmr_load, tmr_zero;
  logic [TIMER_W-1:0] tmr_val, cool_ld;

  assign kill = rst | gamestart | !boss;

  tick_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk22),
    .clear (kill),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  // Launch handshake: fire_* is a one-cycle request; the datapath acknowledges
  // by raising *_busy. The volley is done once busy has been seen and dropped,
  // or when busy never rose within WAIT_TIMEOUT cycles.
  always_comb begin
    state_n    = state_q;
    phase_n    = phase_q;
    volley_n   = volley_q;
    seen_n     = seen_q;
    fire_fan_n = 1'b0;
    fire_big_n = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    enrage_now = (phase_q == PH_ENRAGE) ||
                 ((phase_q == PH_NORMAL) && (boss_hp < ENRAGE_HP));
    target     = enrage_now ? VOLLEY_MAX : VOLLEY_NORM;
    cool_ld    = enrage_now ? COOL_ENR_LD : COOL_LD;
    shootable  = state_q inside {ST_FAN, ST_FAN_WAIT, ST_BIG, ST_BIG_WAIT, ST_COOL};
    if (enrage_now) phase_n = PH_ENRAGE;

    if (kill) begin
      state_n  = ST_IDLE;
      phase_n  = PH_INACTIVE;
      volley_n = '0;
      seen_n   = 1'b0;
    end else if ((state_q != ST_IDLE) && (boss_hp == 8'd0)) begin
      state_n = ST_DEAD;
      phase_n = PH_DEAD;
    end else if (shot && shootable) begin
      state_n  = ST_FREEZE;
      tmr_load = 1'b1;
      tmr_val  = FREEZE_LD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_n  = ST_INTRO;
          tmr_load = 1'b1;
          tmr_val  = INTRO_LD;
        end
        ST_INTRO: if (tmr_zero) begin
          state_n  = ST_FAN;
          volley_n = '0;
          phase_n  = PH_NORMAL;
        end
        ST_FAN: if (!fan_busy) begin
          fire_fan_n = 1'b1;
          volley_n   = (volley_q == VOLLEY_MAX) ? volley_q : volley_q + 3'd1;
          state_n    = ST_FAN_WAIT;
          seen_n     = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = WAIT_LD;
        end
        ST_FAN_WAIT: begin
          seen_n = seen_q | fan_busy;
          if (!fan_busy && (seen_q || tmr_zero))
            state_n = (volley_q < target) ? ST_FAN : ST_BIG;
        end
        ST_BIG: if (!big_busy) begin
          fire_big_n = 1'b1;
          state_n    = ST_BIG_WAIT;
          seen_n     = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = WAIT_LD;
        end
        ST_BIG_WAIT: begin
          seen_n = seen_q | big_busy;
          if (!big_busy && (seen_q || tmr_zero)) begin
            state_n  = ST_COOL;
            tmr_load = 1'b1;
            tmr_val  = cool_ld;
          end
        end
        ST_COOL: if (tmr_zero) begin
          state_n  = ST_FAN;
          volley_n = '0;
        end
        ST_FREEZE: if (tmr_zero) begin
          state_n  = ST_COOL;
          tmr_load = 1'b1;
          tmr_val  = cool_ld;
        end
        ST_DEAD: state_n = ST_DEAD;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk22) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_INACTIVE;
      volley_q <= '0;
      seen_q   <= 1'b0;
      fire_fan <= 1'b0;
      fire_big <= 1'b0;
    end else begin
      state_q  <= state_n;
      phase_q  <= phase_n;
      volley_q <= volley_n;
      seen_q   <= seen_n;
      fire_fan <= fire_fan_n;
      fire_big <= fire_big_n;
    end
  end

  assign state      = state_q;
  assign phase      = phase_q;
  assign volley_cnt = volley_q;

endmodule

// File: tb/tb_boss_pattern_ctrl.sv
// Bench for boss_pattern_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a cycle model.
module tb_boss_pattern_ctrl;
  import boss_ctrl_pkg::*;

  logic       clk22 = 1'b0;
  logic       rst, gamestart, boss, fan_busy, big_busy, shot;
  logic [7:0] boss_hp;
  logic       fire_fan, fire_big;
  logic [1:0] phase;
  logic [2:0] volley_cnt;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk22 = ~clk22;

  boss_pattern_ctrl dut (
    .clk22      (clk22),
    .rst        (rst),
    .gamestart  (gamestart),
    .boss       (boss),
    .boss_hp    (boss_hp),
    .fan_busy   (fan_busy),
    .big_busy   (big_busy),
    .shot       (shot),
    .fire_fan   (fire_fan),
    .fire_big   (fire_big),
    .phase      (phase),
    .volley_cnt (volley_cnt),
    .state      (state)
  );

  // Reference model: cycles remaining in the current timed state, counted down
  state_t m_st = ST_IDLE;
  int     m_ph = 0, m_vc = 0, m_left = 0;
  bit     m_seen = 0, m_ff = 0, m_fb = 0;

  task automatic model_step();
    bit enr;
    int target, cool;
    m_ff = 0;
    m_fb = 0;
    if (rst || gamestart || !boss) begin
      m_st = ST_IDLE; m_ph = 0; m_vc = 0; m_left = 0; m_seen = 0;
      return;
    end
    enr    = (m_ph == 2) || (m_ph == 1 && boss_hp < 64);
    target = enr ? 4 : 3;
    cool   = enr ? 8 : 16;
    if (m_st != ST_IDLE && boss_hp == 0) begin
      m_st = ST_DEAD; m_ph = 3;
      return;
    end
    if (enr) m_ph = 2;
    if (shot && (m_st inside {ST_FAN, ST_FAN_WAIT, ST_BIG, ST_BIG_WAIT, ST_COOL})) begin
      m_st = ST_FREEZE; m_left = 24;
      return;
    end
    case (m_st)
      ST_IDLE: begin m_st = ST_INTRO; m_left = 32; end
      ST_INTRO:
        if (m_left == 1) begin m_st = ST_FAN; m_vc = 0; m_ph = 1; end
        else m_left--;
      ST_FAN:
        if (!fan_busy) begin
          m_ff = 1; m_vc = (m_vc < 4) ? m_vc + 1 : 4;
          m_st = ST_FAN_WAIT; m_seen = 0; m_left = 4;
        end
      ST_FAN_WAIT: begin
        if (fan_busy) m_seen = 1;
        if (!fan_busy && (m_seen || m_left == 1)) m_st = (m_vc < target) ? ST_FAN : ST_BIG;
        else if (m_left > 1) m_left--;
      end
      ST_BIG:
        if (!big_busy) begin
          m_fb = 1; m_st = ST_BIG_WAIT; m_seen = 0; m_left = 4;
        end
      ST_BIG_WAIT: begin
        if (big_busy) m_seen = 1;
        if (!big_busy && (m_seen || m_left == 1)) begin m_st = ST_COOL; m_left = cool; end
        else if (m_left > 1) m_left--;
      end
      ST_COOL:
        if (m_left == 1) begin m_st = ST_FAN; m_vc = 0; end
        else m_left--;
      ST_FREEZE:
        if (m_left == 1) begin m_st = ST_COOL; m_left = cool; end
        else m_left--;
      default: ;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk22);
    model_step();
    #1;
  endtask

  function automatic logic [10:0] dut_out();
    return {state, phase, volley_cnt, fire_fan, fire_big};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d ph=%0d vc=%0d ff=%0b fb=%0b, want st=%0d ph=%0d vc=%0d ff=%0b fb=%0b",
               name, act[10:7], act[6:5], act[4:2], act[1], act[0],
               exp[10:7], exp[6:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic wait_state(input state_t s, input int budget, input string name);
    int n = 0;
    while (state != s && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (state != s) begin
      errors++;
      $display("FAIL %s: timed out after %0d cycles, state=%0d want=%0d", name, n, state, s);
    end
  endtask

  typedef struct {
    logic       r, b, g, fb, bb, sh;
    logic [7:0] hp;
    int         n;
    state_t     st;
    logic [1:0] ph;
    logic [2:0] vc;
    logic       ff, fbig;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, b, g, fb, bb, sh, input logic [7:0] hp,
                             input int n, input state_t st, input logic [1:0] ph,
                             input logic [2:0] vc, input logic ff, fbig);
    vec_t x;
    x.r = r; x.b = b; x.g = g; x.fb = fb; x.bb = bb; x.sh = sh; x.hp = hp; x.n = n;
    x.st = st; x.ph = ph; x.vc = vc; x.ff = ff; x.fbig = fbig;
    return x;
  endfunction

  int fan_dly = 0, fan_len = 0, big_dly = 0, big_len = 0, lat, r;

  initial begin
    rst = 1; gamestart = 0; boss = 0; fan_busy = 0; big_busy = 0; shot = 0; boss_hp = 8'd100;

    //             r  b  g fb bb sh  hp   n   state        ph vc ff fb
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 100,  2, ST_IDLE,     0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_INTRO,    0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100, 31, ST_INTRO,    0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN,      1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN_WAIT, 1, 1, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN_WAIT, 1, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  3, ST_FAN,      1, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 100,  2, ST_FAN,      1, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN_WAIT, 1, 2, 1, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 100,  6, ST_FAN_WAIT, 1, 2, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN,      1, 2, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN_WAIT, 1, 3, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  4, ST_BIG,      1, 3, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 100,  1, ST_BIG,      1, 3, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_BIG_WAIT, 1, 3, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  4, ST_COOL,     1, 3, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100, 15, ST_COOL,     1, 3, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN,      1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 100,  1, ST_FREEZE,   1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  9, ST_FREEZE,   1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 100,  1, ST_FREEZE,   1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100, 13, ST_FREEZE,   1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_COOL,     1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100, 16, ST_FAN,      1, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 0,  63,  1, ST_FAN,      2, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN_WAIT, 2, 1, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  4, ST_FAN,      2, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100, 10, ST_FAN,      2, 3, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN_WAIT, 2, 4, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  4, ST_BIG,      2, 4, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_BIG_WAIT, 2, 4, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  4, ST_COOL,     2, 4, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  7, ST_COOL,     2, 4, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN,      2, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_FAN_WAIT, 2, 1, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,   0,  1, ST_DEAD,     3, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  3, ST_DEAD,     3, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 100,  1, ST_IDLE,     0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 100,  1, ST_INTRO,    0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 100,  5, ST_INTRO,    0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 100,  1, ST_IDLE,     0, 0, 0, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].r; boss = tbl[i].b; gamestart = tbl[i].g;
      fan_busy = tbl[i].fb; big_busy = tbl[i].bb; shot = tbl[i].sh; boss_hp = tbl[i].hp;
      repeat (tbl[i].n) cyc();
      chk($sformatf("vec%0d", i), dut_out(),
          {tbl[i].st, tbl[i].ph, tbl[i].vc, tbl[i].ff, tbl[i].fbig});
    end

    // Boss rise to first fan pulse, counted from the edge that samples boss
    rst = 0; boss = 1; shot = 0; fan_busy = 0; big_busy = 0; boss_hp = 8'd100;
    cyc();
    lat = 0;
    while (!fire_fan && lat < 100) begin
      cyc();
      lat++;
    end
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL latency: got %0d cycles, want 33", lat);
    end

    // gamestart while a big bullet is in flight clears everything next edge
    wait_state(ST_BIG_WAIT, 200, "reach_big_wait");
    gamestart = 1;
    cyc();
    chk("gamestart_big_wait", dut_out(), {ST_IDLE, 2'd0, 3'd0, 1'b0, 1'b0});
    gamestart = 0;

    // Busy rising before the timeout holds FAN_WAIT past it until busy drops
    wait_state(ST_FAN_WAIT, 100, "reach_fan_wait");
    fan_busy = 1;
    repeat (8) cyc();
    chk("seen_busy_hold", dut_out(), {ST_FAN_WAIT, 2'd1, 3'd1, 1'b0, 1'b0});
    fan_busy = 0;
    cyc();
    chk("seen_busy_drop", dut_out(), {ST_FAN, 2'd1, 3'd1, 1'b0, 1'b0});

    // Randomized traffic with a simple bullet datapath driving the busy flags
    rst = 1;
    cyc();
    rst = 0;
    for (int c = 0; c < 4000; c++) begin
      boss      = ($urandom_range(0, 399) != 0);
      gamestart = ($urandom_range(0, 799) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      shot      = ($urandom_range(0, 69) == 0);
      if ($urandom_range(0, 59) == 0) begin
        r = $urandom_range(0, 19);
        boss_hp = (r == 0) ? 8'd0 :
                  (r < 7)  ? 8'($urandom_range(1, 63)) : 8'($urandom_range(64, 255));
      end
      if (fan_dly > 0) begin fan_busy = 0; fan_dly--; end
      else if (fan_len > 0) begin fan_busy = 1; fan_len--; end
      else fan_busy = ($urandom_range(0, 39) == 0);
      if (big_dly > 0) begin big_busy = 0; big_dly--; end
      else if (big_len > 0) begin big_busy = 1; big_len--; end
      else big_busy = ($urandom_range(0, 39) == 0);
      cyc();
      chk("rand", dut_out(), {m_st, 2'(m_ph), 3'(m_vc), m_ff, m_fb});
      if (fire_fan && $urandom_range(0, 4) != 0) begin
        fan_dly = $urandom_range(0, 2); fan_len = $urandom_range(1, 12);
      end
      if (fire_big && $urandom_range(0, 4) != 0) begin
        big_dly = $urandom_range(0, 2); big_len = $urandom_range(1, 12);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
